alu_operand_stage: RTL and testbench

//  Operand-fetch/writeback stage wrapped around the ALU. Holds the core's register file,

---
 rtl/alu_operand_stage_if.sv | 28 ++
 rtl/alu_operand_stage.sv | 132 +++++++++++++
 tb/tb_alu_operand_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// Instruction issue bundle between the issuer and the ALU operand stage.
// The issuer drives the instruction fields; the stage answers with ready.
interface alu_operand_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  valid;
  logic                  ready;
  logic [2:0]            ctrl;
  logic [ADDR_WIDTH-1:0] rs0;
  logic [ADDR_WIDTH-1:0] rs1;
  logic                  use_imm;
  logic [DATA_WIDTH-1:0] imm;
  logic [ADDR_WIDTH-1:0] rd;
  logic                  wen;

  modport master (
    output valid, ctrl, rs0, rs1,
    output use_imm, imm, rd, wen,
    input  ready
  );

  modport slave (
    input  valid, ctrl, rs0, rs1,
    input  use_imm, imm, rd, wen,
    output ready
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand fetch / writeback stage around an external ALU.
// Holds the register file, forwards from S2 and stalls on S1 hazards.
module alu_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_operand_stage_if.slave    instr,
  output logic [2:0]            alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_in0,
  output logic [DATA_WIDTH-1:0] alu_in1,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic                  wb_valid,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  cond_valid,
  output logic                  cond_out
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [DEPTH];

  logic                  s1_valid;
  logic [2:0]            s1_ctrl;
  logic [DATA_WIDTH-1:0] s1_op0;
  logic [DATA_WIDTH-1:0] s1_op1;
  logic [ADDR_WIDTH-1:0] s1_rd;
  logic                  s1_wen;

  logic                  s2_valid;
  logic [2:0]            s2_ctrl;
  logic [ADDR_WIDTH-1:0] s2_rd;
  logic                  s2_wen;

  logic                  hazard;
  logic                  accept;
  logic                  fwd0;
  logic                  fwd1;
  logic [DATA_WIDTH-1:0] op0;
  logic [DATA_WIDTH-1:0] op1;
  logic                  is_cmp;

  // S1 result is not available yet, so a reader of S1.rd must wait a cycle
  always_comb begin
    hazard = 1'b0;
    if (s1_valid && s1_wen) begin
      hazard = (s1_rd == instr.rs0) ||
               (!instr.use_imm && s1_rd == instr.rs1);
    end
  end

  assign instr.ready = !hazard;
  assign accept      = instr.valid && !hazard;

  assign fwd0 = s2_valid && s2_wen &&
                (s2_rd == instr.rs0);
  assign fwd1 = s2_valid && s2_wen &&
                (s2_rd == instr.rs1);

  always_comb begin
    op0 = fwd0 ? alu_out : rf[instr.rs0];
    op1 = fwd1 ? alu_out : rf[instr.rs1];
    if (instr.use_imm) op1 = instr.imm;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_op0   <= '0;
      s1_op1   <= '0;
      s1_rd    <= '0;
      s1_wen   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_ctrl  <= instr.ctrl;
      s1_op0   <= op0;
      s1_op1   <= op1;
      s1_rd    <= instr.rd;
      s1_wen   <= instr.wen;
    end else begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_op0   <= '0;
      s1_op1   <= '0;
      s1_rd    <= '0;
      s1_wen   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_ctrl  <= '0;
      s2_rd    <= '0;
      s2_wen   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_ctrl  <= s1_ctrl;
      s2_rd    <= s1_rd;
      s2_wen   <= s1_wen;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (wb_valid) begin
      rf[s2_rd] <= alu_out;
    end
  end

  always_comb begin
    is_cmp = 1'b0;
    unique case (1'b1)
      (s2_ctrl == 3'd3): is_cmp = 1'b1;
      (s2_ctrl == 3'd4): is_cmp = 1'b1;
      (s2_ctrl == 3'd5): is_cmp = 1'b1;
      default:           is_cmp = 1'b0;
    endcase
  end

  assign alu_in0    = s1_op0;
  assign alu_in1    = s1_op1;
  assign alu_ctrl   = s2_ctrl;
  assign wb_valid   = s2_valid && s2_wen;
  assign wb_addr    = wb_valid ? s2_rd : '0;
  assign wb_data    = wb_valid ? alu_out : '0;
  assign cond_valid = s2_valid && is_cmp;
  assign cond_out   = cond_valid && alu_out[0];
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a registered-input ALU model.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_operand_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [31:0] alu_out;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        cond_valid;
  logic        cond_out;

  logic [31:0] a = '0;
  logic [31:0] b = '0;

  int tests = 0;
  int fails = 0;

  alu_operand_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  alu_operand_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (bus),
    .alu_ctrl   (alu_ctrl),
    .alu_in0    (alu_in0),
    .alu_in1    (alu_in1),
    .alu_out    (alu_out),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .cond_valid (cond_valid),
    .cond_out   (cond_out)
  );

  always #5 clk = ~clk;

  // ALU: inputs registered, ctrl combinational, signed compares
  always @(posedge clk) begin
    a <= alu_in0;
    b <= alu_in1;
  end

  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      3'd0: alu_out = a;
      3'd1: alu_out = a + b;
      3'd2: alu_out = a - b;
      3'd3: alu_out = {31'd0, a == b};
      3'd4: alu_out = {31'd0, $signed(a) <= $signed(b)};
      3'd5: alu_out = {31'd0, $signed(a) >= $signed(b)};
      default: alu_out = '0;
    endcase
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] c, input logic [3:0] r0,
                     input logic [3:0] r1, input logic ui,
                     input logic [31:0] im, input logic [3:0] d,
                     input logic w);
    bus.valid   = 1'b1;
    bus.ctrl    = c;
    bus.rs0     = r0;
    bus.rs1     = r1;
    bus.use_imm = ui;
    bus.imm     = im;
    bus.rd      = d;
    bus.wen     = w;
    #1;
  endtask

  task automatic idle();
    bus.valid   = 1'b0;
    bus.ctrl    = '0;
    bus.rs0     = '0;
    bus.rs1     = '0;
    bus.use_imm = 1'b0;
    bus.imm     = '0;
    bus.rd      = '0;
    bus.wen     = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    nxt();
    nxt();
    tests++;
    if ({wb_valid, cond_valid, alu_ctrl} !== 5'd0) begin
      fails++;
      $display("FAIL reset_ctl got wb=%b cv=%b ctrl=%0d exp 0",
               wb_valid, cond_valid, alu_ctrl);
    end
    tests++;
    if ({alu_in0, alu_in1, wb_data} !== 96'd0) begin
      fails++;
      $display("FAIL reset_data got in0=%h in1=%h wbd=%h exp 0",
               alu_in0, alu_in1, wb_data);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b exp 1", bus.ready);
    end
  endtask

  task automatic test_first_write();
    put(3'd1, 4'd0, 4'd0, 1'b1, 32'd5, 4'd1, 1'b1);
    nxt();
    idle();
    tests++;
    if ({alu_in0, alu_in1} !== {32'd0, 32'd5} || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL t1_s1 got in0=%h in1=%h wb=%b exp 0 5 0",
               alu_in0, alu_in1, wb_valid);
    end
    nxt();
    tests++;
    if (wb_valid !== 1'b1 || wb_addr !== 4'd1 || wb_data !== 32'd5) begin
      fails++;
      $display("FAIL t1_wb got v=%b a=%0d d=%h exp 1 1 5",
               wb_valid, wb_addr, wb_data);
    end
    tests++;
    if (alu_ctrl !== 3'd1 || cond_valid !== 1'b0) begin
      fails++;
      $display("FAIL t1_ctrl got ctrl=%0d cv=%b exp 1 0",
               alu_ctrl, cond_valid);
    end
    nxt();
  endtask

  task automatic test_back_to_back();
    put(3'd1, 4'd1, 4'd0, 1'b1, 32'd3, 4'd2, 1'b1);
    tests++;
    if (bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL t2_rdy0 got %b exp 1", bus.ready);
    end
    nxt();
    put(3'd2, 4'd2, 4'd0, 1'b1, 32'd1, 4'd3, 1'b1);
    tests++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL t2_stall got %b exp 0", bus.ready);
    end
    nxt();
    tests++;
    if (bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL t2_rdy1 got %b exp 1", bus.ready);
    end
    tests++;
    if (wb_valid !== 1'b1 || wb_addr !== 4'd2 || wb_data !== 32'd8) begin
      fails++;
      $display("FAIL t2_wb_r2 got v=%b a=%0d d=%h exp 1 2 8",
               wb_valid, wb_addr, wb_data);
    end
    nxt();
    idle();
    tests++;
    if ({alu_in0, alu_in1} !== {32'd8, 32'd1} || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL t2_fwd got in0=%h in1=%h wb=%b exp 8 1 0",
               alu_in0, alu_in1, wb_valid);
    end
    nxt();
    tests++;
    if (wb_valid !== 1'b1 || wb_addr !== 4'd3 || wb_data !== 32'd7) begin
      fails++;
      $display("FAIL t2_wb_r3 got v=%b a=%0d d=%h exp 1 3 7",
               wb_valid, wb_addr, wb_data);
    end
    nxt();
  endtask

  task automatic test_forward();
    put(3'd1, 4'd1, 4'd0, 1'b1, 32'd10, 4'd4, 1'b1);
    nxt();
    put(3'd1, 4'd0, 4'd4, 1'b1, 32'd2, 4'd9, 1'b1);
    tests++;
    if (bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL t3_imm_rs1 got %b exp 1", bus.ready);
    end
    nxt();
    put(3'd1, 4'd4, 4'd0, 1'b1, 32'd0, 4'd10, 1'b1);
    tests++;
    if (bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL t3_nostall got %b exp 1", bus.ready);
    end
    tests++;
    if (wb_addr !== 4'd4 || wb_data !== 32'd15) begin
      fails++;
      $display("FAIL t3_wb_r4 got a=%0d d=%h exp 4 f",
               wb_addr, wb_data);
    end
    nxt();
    idle();
    tests++;
    if (wb_addr !== 4'd9 || wb_data !== 32'd2) begin
      fails++;
      $display("FAIL t3_wb_r9 got a=%0d d=%h exp 9 2",
               wb_addr, wb_data);
    end
    nxt();
    tests++;
    if (wb_valid !== 1'b1 || wb_addr !== 4'd10 ||
        wb_data !== 32'd15) begin
      fails++;
      $display("FAIL t3_wb_r10 got v=%b a=%0d d=%h exp 1 10 f",
               wb_valid, wb_addr, wb_data);
    end
    nxt();
  endtask

  task automatic test_compare();
    put(3'd1, 4'd0, 4'd0, 1'b1, 32'hFFFF_FFFF, 4'd5, 1'b1);
    nxt();
    put(3'd1, 4'd0, 4'd0, 1'b1, 32'd1, 4'd6, 1'b1);
    nxt();
    put(3'd4, 4'd5, 4'd6, 1'b0, 32'd0, 4'd11, 1'b0);
    tests++;
    if (bus.ready !== 1'b0) begin
      fails++;
      $display("FAIL t4_rs1_stall got %b exp 0", bus.ready);
    end
    nxt();
    tests++;
    if (bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL t4_rdy got %b exp 1", bus.ready);
    end
    nxt();
    put(3'd5, 4'd5, 4'd6, 1'b0, 32'd0, 4'd12, 1'b0);
    tests++;
    if ({alu_in0, alu_in1} !== {32'hFFFF_FFFF, 32'd1}) begin
      fails++;
      $display("FAIL t4_ops got in0=%h in1=%h exp ffffffff 1",
               alu_in0, alu_in1);
    end
    nxt();
    idle();
    tests++;
    if (cond_valid !== 1'b1 || cond_out !== 1'b1 || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL t4_le got cv=%b co=%b wb=%b exp 1 1 0",
               cond_valid, cond_out, wb_valid);
    end
    nxt();
    tests++;
    if (cond_valid !== 1'b1 || cond_out !== 1'b0 || wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL t4_ge got cv=%b co=%b wb=%b exp 1 0 0",
               cond_valid, cond_out, wb_valid);
    end
    nxt();
  endtask

  task automatic test_wrap();
    put(3'd2, 4'd0, 4'd0, 1'b1, 32'd1, 4'd7, 1'b1);
    nxt();
    idle();
    nxt();
    put(3'd0, 4'd7, 4'd0, 1'b1, 32'd0, 4'd0, 1'b0);
    tests++;
    if (wb_addr !== 4'd7 || wb_data !== 32'hFFFF_FFFF ||
        cond_valid !== 1'b0) begin
      fails++;
      $display("FAIL t5_wrap got a=%0d d=%h cv=%b exp 7 ffffffff 0",
               wb_addr, wb_data, cond_valid);
    end
    nxt();
    idle();
    tests++;
    if (alu_in0 !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL t5_read got %h exp ffffffff", alu_in0);
    end
    nxt();
    nxt();
  endtask

  task automatic test_reset_inflight();
    put(3'd1, 4'd0, 4'd0, 1'b1, 32'd9, 4'd8, 1'b1);
    nxt();
    idle();
    reset = 1'b1;
    #1;
    tests++;
    if (alu_in0 !== 32'd0 || alu_in1 !== 32'd0) begin
      fails++;
      $display("FAIL t6_clr got in0=%h in1=%h exp 0 0",
               alu_in0, alu_in1);
    end
    nxt();
    tests++;
    if (wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL t6_nowb got %b exp 0", wb_valid);
    end
    reset = 1'b0;
    nxt();
    tests++;
    if (wb_valid !== 1'b0 || bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL t6_post got wb=%b rdy=%b exp 0 1",
               wb_valid, bus.ready);
    end
    put(3'd0, 4'd8, 4'd0, 1'b1, 32'd0, 4'd0, 1'b0);
    nxt();
    idle();
    tests++;
    if (alu_in0 !== 32'd0) begin
      fails++;
      $display("FAIL t6_r8 got %h exp 0", alu_in0);
    end
    nxt();
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_back_to_back();
    test_forward();
    test_compare();
    test_wrap();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
